// File: rtl/gate_test_pkg.sv
// Shared types and reference truth tables for the gate sweep controller.
// Truth-table bit index is {a, b}.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/settle_timer.sv
// Settle counter: clears on clr, counts while en, flags when it reaches TERM.
module settle_timer #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned TERM  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CNT_W'(TERM));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Drives all four input vectors into an external 2-input gate, captures its
// output per vector and compares the measured truth table against EXP_TT.
module gate_sweep_ctrl
  import gate_test_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXP_TT        = TT_XNOR,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [3:0] result_tt
);

  state_t     state;
  logic [1:0] idx;
  logic       tmr_clr;
  logic       tmr_en;
  logic       tmr_tc;

  // Counter only runs in SETTLE; leaving SAMPLE therefore always re-enters at 0.
  assign tmr_en  = (state == SETTLE);
  assign tmr_clr = (state != SETTLE);

  settle_timer #(
    .CNT_W (CNT_W),
    .TERM  (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      result_tt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state           <= SETTLE;
            idx             <= '0;
            {gate_a, gate_b} <= 2'b00;
            busy            <= 1'b1;
            result_tt       <= '0;
            pass            <= 1'b0;
            fail_mask       <= '0;
          end
        end
        SETTLE: begin
          if (tmr_tc) state <= SAMPLE;
        end
        SAMPLE: begin
          result_tt[idx] <= gate_y;
          if (idx == 2'd3) begin
            state <= DONE;
          end else begin
            idx              <= idx + 2'd1;
            {gate_a, gate_b} <= idx + 2'd1;
            state            <= SETTLE;
          end
        end
        DONE: begin
          pass      <= (result_tt == EXP_TT);
          fail_mask <= result_tt ^ EXP_TT;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench: one default-parameter controller with a switchable gate model
// and one zero-settle controller driving an AND gate.
module tb_gate_sweep_ctrl;
  import gate_test_pkg::*;

  logic clk;
  logic rst;

  logic       start0, a0, b0, y0, busy0, done0, pass0;
  logic [3:0] mask0, res0;
  logic [3:0] gate_tt0;

  logic       start1, a1, b1, y1, busy1, done1, pass1;
  logic [3:0] mask1, res1;

  int total;
  int bad;

  assign y0 = gate_tt0[{a0, b0}];
  assign y1 = a1 & b1;

  gate_sweep_ctrl u_def (
    .clk (clk), .rst (rst), .start (start0),
    .gate_a (a0), .gate_b (b0), .gate_y (y0),
    .busy (busy0), .done (done0), .pass (pass0),
    .fail_mask (mask0), .result_tt (res0)
  );

  gate_sweep_ctrl #(
    .SETTLE_CYCLES (0),
    .EXP_TT        (TT_AND),
    .CNT_W         (4)
  ) u_fast (
    .clk (clk), .rst (rst), .start (start1),
    .gate_a (a1), .gate_b (b1), .gate_y (y1),
    .busy (busy1), .done (done1), .pass (pass1),
    .fail_mask (mask1), .result_tt (res1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a one-cycle start on u_def and returns the number of cycles from the
  // start edge to the done pulse (60 if it never comes).
  task automatic run_def(output int n);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      n = i;
      if (done0) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++;
    if ({a0, b0, busy0, done0, pass0, mask0, res0} !== 13'd0) begin
      bad++;
      $display("FAIL reset_def: got %b expected all zero", {a0, b0, busy0, done0, pass0, mask0, res0});
    end
    total++;
    if ({a1, b1, busy1, done1, pass1, mask1, res1} !== 13'd0) begin
      bad++;
      $display("FAIL reset_fast: got %b expected all zero", {a1, b1, busy1, done1, pass1, mask1, res1});
    end
  endtask

  task automatic test_xnor_pass();
    int n;
    gate_tt0 = TT_XNOR;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    total++;
    if (busy0 !== 1'b1) begin
      bad++;
      $display("FAIL xnor_busy_rise: got %b expected 1", busy0);
    end
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      n = i;
      if (done0) break;
    end
    total++;
    if (n !== 17) begin
      bad++;
      $display("FAIL xnor_latency: got %0d expected 17", n);
    end
    total++;
    if ({res0, pass0, mask0, busy0} !== {4'b1001, 1'b1, 4'b0000, 1'b0}) begin
      bad++;
      $display("FAIL xnor_result: got res=%b pass=%b mask=%b busy=%b expected res=1001 pass=1 mask=0000 busy=0",
               res0, pass0, mask0, busy0);
    end
    step();
    total++;
    if ({done0, pass0, a0, b0} !== 4'b0111) begin
      bad++;
      $display("FAIL xnor_hold: got done=%b pass=%b ab=%b%b expected done=0 pass=1 ab=11", done0, pass0, a0, b0);
    end
  endtask

  task automatic test_xor_mismatch();
    int n;
    gate_tt0 = TT_XOR;
    run_def(n);
    total++;
    if (n !== 17) begin
      bad++;
      $display("FAIL xor_latency: got %0d expected 17", n);
    end
    total++;
    if ({res0, pass0, mask0} !== {4'b0110, 1'b0, 4'b1111}) begin
      bad++;
      $display("FAIL xor_result: got res=%b pass=%b mask=%b expected res=0110 pass=0 mask=1111", res0, pass0, mask0);
    end
    step();
  endtask

  task automatic test_zero_settle();
    int n;
    int ab_bad;
    logic [1:0] exp_ab;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    total++;
    if ({a1, b1} !== 2'b00) begin
      bad++;
      $display("FAIL fast_first_vec: got %b%b expected 00", a1, b1);
    end
    n = 0;
    ab_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      n = k;
      exp_ab = (k >= 6) ? 2'd3 : 2'(k / 2);
      if ({a1, b1} !== exp_ab) begin
        ab_bad++;
        $display("FAIL fast_vector_step: cycle %0d got %b%b expected %b", k, a1, b1, exp_ab);
      end
      if (done1) break;
    end
    total++;
    if (ab_bad !== 0) begin
      bad++;
      $display("FAIL fast_vector_seq: got %0d wrong cycles expected 0", ab_bad);
    end
    total++;
    if (n !== 9) begin
      bad++;
      $display("FAIL fast_latency: got %0d expected 9", n);
    end
    total++;
    if ({res1, pass1, mask1} !== {4'b1000, 1'b1, 4'b0000}) begin
      bad++;
      $display("FAIL fast_result: got res=%b pass=%b mask=%b expected res=1000 pass=1 mask=0000", res1, pass1, mask1);
    end
    step();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    gate_tt0 = TT_XNOR;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 11; i++) step();
    // Now in SAMPLE for vector 2: vectors 0 and 1 already captured.
    total++;
    if ({a0, b0, busy0, res0} !== {2'b10, 1'b1, 4'b0001}) begin
      bad++;
      $display("FAIL mid_before_reset: got ab=%b%b busy=%b res=%b expected ab=10 busy=1 res=0001", a0, b0, busy0, res0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({a0, b0, busy0, done0, pass0, mask0, res0} !== 13'd0) begin
      bad++;
      $display("FAIL mid_reset_clear: got %b expected all zero", {a0, b0, busy0, done0, pass0, mask0, res0});
    end
    step();
    total++;
    if ({busy0, done0} !== 2'b00) begin
      bad++;
      $display("FAIL mid_reset_idle: got busy=%b done=%b expected 0 0", busy0, done0);
    end
    run_def(n);
    total++;
    if ({n == 17, res0, pass0} !== {1'b1, 4'b1001, 1'b1}) begin
      bad++;
      $display("FAIL mid_rerun: got lat=%0d res=%b pass=%b expected lat=17 res=1001 pass=1", n, res0, pass0);
    end
    step();
  endtask

  task automatic test_ignored_start();
    int pulses;
    int first;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    step();
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    pulses = 0;
    first  = 0;
    for (int k = 4; k <= 36; k++) begin
      step();
      if (done0) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    total++;
    if ({pulses, first} !== {32'd1, 32'd17}) begin
      bad++;
      $display("FAIL ignored_start: got pulses=%0d first=%0d expected pulses=1 first=17", pulses, first);
    end
    total++;
    if (busy0 !== 1'b0) begin
      bad++;
      $display("FAIL ignored_start_idle: got busy=%b expected 0", busy0);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int t1;
    int t2;
    logic [3:0] res_at_17;
    logic [3:0] res_at_18;
    logic       busy_at_18;
    start0 = 1'b1;
    step();
    pulses = 0;
    t1 = 0;
    t2 = 0;
    res_at_17 = 'x;
    res_at_18 = 'x;
    busy_at_18 = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 17) res_at_17 = res0;
      if (k == 18) begin
        res_at_18  = res0;
        busy_at_18 = busy0;
      end
      if (done0) begin
        pulses++;
        if (pulses == 1) t1 = k;
        if (pulses == 2) t2 = k;
      end
    end
    start0 = 1'b0;
    total++;
    if ({pulses, t1, t2} !== {32'd2, 32'd17, 32'd35}) begin
      bad++;
      $display("FAIL b2b_pulses: got pulses=%0d at %0d,%0d expected 2 at 17,35", pulses, t1, t2);
    end
    total++;
    if ({res_at_17, res_at_18, busy_at_18} !== {4'b1001, 4'b0000, 1'b1}) begin
      bad++;
      $display("FAIL b2b_clear: got res17=%b res18=%b busy18=%b expected 1001 0000 1", res_at_17, res_at_18, busy_at_18);
    end
    for (int k = 0; k < 40 && busy0; k++) step();
    total++;
    if (busy0 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: got busy=%b expected 0", busy0);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    start0   = 1'b0;
    start1   = 1'b0;
    gate_tt0 = TT_XNOR;
    #1;
    test_reset();
    test_xnor_pass();
    test_xor_mismatch();
    test_zero_settle();
    test_reset_mid_sweep();
    test_ignored_start();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
